div_seq: RTL and testbench

- Sequential restoring divider; the inverse of the team's 6x6 shift-add multiplier.
- Takes a 2*WIDTH-bit dividend and a WIDTH-bit divisor.
- Produces a 2*WIDTH-bit quotient and a WIDTH-bit remainder, one quotient bit per clock.
- Sits beside the multiplier in the arithmetic datapath; same start/enable input style, with a busy/done handshake added.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_step.sv | 30 +++
 rtl/div_seq.sv | 132 +++++++++++++
 tb/tb_div_seq.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the sequential restoring divider.
//   DIV_WIDTH : default divisor/remainder width (dividend/quotient are 2x).
//   DIV_CNT_W : iteration counter width for the default width.
//   state_t   : divider FSM states.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 6;
  localparam int unsigned DIV_CNT_W = $clog2(2 * DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
//   rem     : current partial remainder (always < dvs)
//   dvs     : divisor
//   din     : next dividend bit shifted into the partial remainder
//   rem_nxt : partial remainder after the conditional subtract
//   qbit    : quotient bit produced by this iteration
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dvs,
  input  logic             din,
  output logic [WIDTH-1:0] rem_nxt,
  output logic             qbit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem, din};
  assign diff    = shifted - {1'b0, dvs};

  // rem < dvs keeps shifted < 2*dvs, so the top bit of the difference is
  // set exactly when the subtract borrows (shifted < dvs).
  assign qbit    = ~diff[WIDTH];
  assign rem_nxt = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_seq.sv
// div_seq: sequential restoring divider, one quotient bit per clock.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   e    : start request (accepted in IDLE or DONE)
//   a    : 2*WIDTH-bit dividend, captured on an accepted start
//   b    : WIDTH-bit divisor, captured on an accepted start
//   q    : 2*WIDTH-bit quotient (registered, held until next completion)
//   r    : WIDTH-bit remainder (registered, held until next completion)
//   busy : high while iterating
//   done : one-cycle pulse, q/r/dz valid
//   dz   : divide-by-zero flag of the last operation
// Optional macro DIV_SIGNED_EN: two's-complement operands; magnitudes are
// divided and signs applied when entering DONE (quotient truncates toward
// zero, remainder takes the dividend sign).
module div_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 e,
  input  logic [2*WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   q,
  output logic [WIDTH-1:0]     r,
  output logic                 busy,
  output logic                 done,
  output logic                 dz
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(DW);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [DW-1:0]    work;   // dividend bits shift out the top, quotient bits in the bottom
  logic [WIDTH-1:0] prem;
  logic [WIDTH-1:0] dvs;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [DW-1:0]    q_raw;
  logic [DW-1:0]    q_fin;
  logic [WIDTH-1:0] r_fin;
  logic [DW-1:0]    a_mag;
  logic [WIDTH-1:0] b_mag;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (prem),
    .dvs     (dvs),
    .din     (work[DW-1]),
    .rem_nxt (step_rem),
    .qbit    (step_q)
  );

  assign q_raw = {work[DW-2:0], step_q};

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  assign a_mag = a[DW-1]    ? (~a + DW'(1))    : a;
  assign b_mag = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
  assign q_fin = neg_q ? (~q_raw + DW'(1))       : q_raw;
  assign r_fin = neg_r ? (~step_rem + WIDTH'(1)) : step_rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state != CALC && e) begin
      neg_q <= a[DW-1] ^ b[WIDTH-1];
      neg_r <= a[DW-1];
    end
  end
`else
  assign a_mag = a;
  assign b_mag = b;
  assign q_fin = q_raw;
  assign r_fin = step_rem;
`endif

  assign busy = (state == CALC);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      work  <= '0;
      prem  <= '0;
      dvs   <= '0;
      q     <= '0;
      r     <= '0;
      dz    <= 1'b0;
    end else begin
      case (state)
        CALC: begin
          work <= q_raw;
          prem <= step_rem;
          cnt  <= cnt - CW'(1);
          if (cnt == '0) begin
            state <= DONE;
            q     <= q_fin;
            r     <= r_fin;
            dz    <= 1'b0;
          end
        end
        default: begin
          if (e) begin
            if (b == '0) begin
              state <= DONE;
              q     <= '1;
              r     <= a[WIDTH-1:0];
              dz    <= 1'b1;
            end else begin
              state <= CALC;
              cnt   <= CW'(DW - 1);
              work  <= a_mag;
              prem  <= '0;
              dvs   <= b_mag;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: randomized self-checking bench for div_seq against an
// arithmetic reference model, plus directed literal expectations.
module tb_div_seq;

  localparam int W  = 6;
  localparam int DW = 12;

  logic          clk;
  logic          rst;
  logic          e;
  logic [DW-1:0] a;
  logic [W-1:0]  b;
  logic [DW-1:0] q;
  logic [W-1:0]  r;
  logic          busy;
  logic          done;
  logic          dz;

  int checks   = 0;
  int failures = 0;

  div_seq #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .e    (e),
    .a    (a),
    .b    (b),
    .q    (q),
    .r    (r),
    .busy (busy),
    .done (done),
    .dz   (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference results computed with plain integer arithmetic.
  function automatic logic [DW-1:0] ref_q(input logic [DW-1:0] av, input logic [W-1:0] bv);
    int qi;
    if (bv == '0) return '1;
`ifdef DIV_SIGNED_EN
    qi = int'($signed(av)) / int'($signed(bv));
`else
    qi = int'(av) / int'(bv);
`endif
    return qi[DW-1:0];
  endfunction

  function automatic logic [W-1:0] ref_r(input logic [DW-1:0] av, input logic [W-1:0] bv);
    int ri;
    if (bv == '0) return av[W-1:0];
`ifdef DIV_SIGNED_EN
    ri = int'($signed(av)) % int'($signed(bv));
`else
    ri = int'(av) % int'(bv);
`endif
    return ri[W-1:0];
  endfunction

  // Model: phase 0 idle, 1 iterating, 2 result cycle; m_left counts edges to completion.
  logic [1:0]    m_ph   = 2'd0;
  int            m_left = 0;
  logic [DW-1:0] m_q    = '0;
  logic [W-1:0]  m_r    = '0;
  logic          m_dz   = 1'b0;
  logic [DW-1:0] pq     = '0;
  logic [W-1:0]  pr     = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph   <= 2'd0;
      m_left <= 0;
      m_q    <= '0;
      m_r    <= '0;
      m_dz   <= 1'b0;
    end else if (m_ph == 2'd1) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_ph <= 2'd2;
        m_q  <= pq;
        m_r  <= pr;
        m_dz <= 1'b0;
      end
    end else if (e) begin
      if (b == '0) begin
        m_ph <= 2'd2;
        m_q  <= ref_q(a, b);
        m_r  <= ref_r(a, b);
        m_dz <= 1'b1;
      end else begin
        m_ph   <= 2'd1;
        m_left <= DW;
        pq     <= ref_q(a, b);
        pr     <= ref_r(a, b);
      end
    end else begin
      m_ph <= 2'd0;
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_ph == 2'd1));
    chk("done", 32'(done), 32'(m_ph == 2'd2));
    chk("q",    32'(q),    32'(m_q));
    chk("r",    32'(r),    32'(m_r));
    chk("dz",   32'(dz),   32'(m_dz));
  end

  task automatic start(input logic [DW-1:0] av, input logic [W-1:0] bv);
    e = 1'b1;
    a = av;
    b = bv;
    @(negedge clk);
    e = 1'b0;
    a = DW'($urandom);
    b = W'($urandom);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL wait_done: got timeout after %0d cycles expected done pulse", n);
    end
  endtask

  int n;
  int ndone;

  initial begin
    rst = 1'b1;
    e   = 1'b0;
    a   = '0;
    b   = '0;
    repeat (3) @(negedge clk);
    chk("rst_q",    32'(q),    32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 100 / 7
    start(12'd100, 6'd7);
    wait_done(n);
    chk("lat_100_7", 32'(n), 32'd12);
    chk("q_100_7", 32'(q), 32'd14);
    chk("r_100_7", 32'(r), 32'd2);
    chk("dz_100_7", 32'(dz), 32'd0);
    chk("model_q_100_7", 32'(m_q), 32'd14);
    @(negedge clk);

    // 4095 / 1 then back-to-back 5 / 63 started in the DONE cycle
    start(12'd4095, 6'd1);
    wait_done(n);
    chk("q_4095_1", 32'(q), 32'd4095);
    chk("r_4095_1", 32'(r), 32'd0);
    start(12'd5, 6'd63);
    wait_done(n);
    chk("lat_b2b", 32'(n), 32'd12);
`ifdef DIV_SIGNED_EN
    chk("q_5_63", 32'(q), 32'hFFB);
    chk("r_5_63", 32'(r), 32'd0);
`else
    chk("q_5_63", 32'(q), 32'd0);
    chk("r_5_63", 32'(r), 32'd5);
    chk("model_r_5_63", 32'(m_r), 32'd5);
`endif
    @(negedge clk);

    // divide by zero
    start(12'd1234, 6'd0);
    wait_done(n);
    chk("lat_dz", 32'(n), 32'd0);
    chk("q_dz", 32'(q), 32'd4095);
    chk("r_dz", 32'(r), 32'd18);
    chk("dz_dz", 32'(dz), 32'd1);
    chk("busy_dz", 32'(busy), 32'd0);
    @(negedge clk);

    // asynchronous reset mid-calculation
    start(12'd3000, 6'd13);
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_q", 32'(q), 32'd0);
    chk("arst_r", 32'(r), 32'd0);
    chk("arst_dz", 32'(dz), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("arst_no_done", 32'(ndone), 32'd0);
    start(12'd50, 6'd5);
    wait_done(n);
    chk("q_50_5", 32'(q), 32'd10);
    chk("r_50_5", 32'(r), 32'd0);
    @(negedge clk);

    // e held high through CALC with changing operands
    e = 1'b1;
    a = 12'd1000;
    b = 6'd9;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 9) e = 1'b0;
      a = DW'($urandom);
      b = W'($urandom);
      if (done) ndone++;
    end
    chk("hold_ndone", 32'(ndone), 32'd1);
    chk("q_1000_9", 32'(q), 32'd111);
    chk("r_1000_9", 32'(r), 32'd1);

`ifdef DIV_SIGNED_EN
    start(12'hF9C, 6'd7);
    wait_done(n);
    chk("q_m100_7", 32'(q), 32'hFF2);
    chk("r_m100_7", 32'(r), 32'h3E);
    @(negedge clk);
    start(12'h800, 6'h3F);
    wait_done(n);
    chk("q_ovf", 32'(q), 32'h800);
    chk("r_ovf", 32'(r), 32'd0);
    chk("dz_ovf", 32'(dz), 32'd0);
    @(negedge clk);
`endif

    // randomized traffic, inputs changed just after the falling edge
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      #1;
      rst = ($urandom_range(0, 149) == 0);
      e   = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 7))
        0:       a = '0;
        1:       a = '1;
        default: a = DW'($urandom);
      endcase
      case ($urandom_range(0, 9))
        0:       b = '0;
        1:       b = 6'd1;
        2:       b = '1;
        default: b = W'($urandom);
      endcase
    end
    @(negedge clk);
    #1;
    rst = 1'b0;
    e   = 1'b0;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
